// File: rtl/axi_lite_master_port_if.sv
// AXI4-Lite bus between a single-outstanding master and its slave.
// The master modport drives address/data/valids; the slave modport answers.
interface axi_lite_master_port_if;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [2:0]  m_arprot;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [2:0]  m_awprot;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;

    modport master (
        output m_araddr, m_arvalid, m_arprot, m_rready,
        output m_awaddr, m_awvalid, m_awprot, m_wdata, m_wstrb, m_wvalid, m_bready,
        input  m_arready, m_rdata, m_rresp, m_rvalid,
        input  m_awready, m_wready, m_bresp, m_bvalid
    );

    modport slave (
        input  m_araddr, m_arvalid, m_arprot, m_rready,
        input  m_awaddr, m_awvalid, m_awprot, m_wdata, m_wstrb, m_wvalid, m_bready,
        output m_arready, m_rdata, m_rresp, m_rvalid,
        output m_awready, m_wready, m_bresp, m_bvalid
    );
endinterface

// File: rtl/axi_lite_master_port.sv
// Turns one core load/store request into one AXI4-Lite transaction and
// returns a single-cycle response pulse; one transaction in flight at a time.
module axi_lite_master_port #(
    parameter logic [2:0] PROT = 3'b000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    axi_lite_master_port_if.master m
);

    typedef enum logic [2:0] {IDLE, AR, R, AWW, B, RESP} state_t;
    state_t state;

    // A channel counts as done once its valid is already low or handshakes now.
    logic aw_done, w_done;
    assign aw_done = !m.m_awvalid || m.m_awready;
    assign w_done  = !m.m_wvalid  || m.m_wready;

    assign m.m_arprot = PROT;
    assign m.m_awprot = PROT;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            m.m_araddr  <= '0;
            m.m_arvalid <= 1'b0;
            m.m_rready  <= 1'b0;
            m.m_awaddr  <= '0;
            m.m_awvalid <= 1'b0;
            m.m_wdata   <= '0;
            m.m_wstrb   <= '0;
            m.m_wvalid  <= 1'b0;
            m.m_bready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (req_we) begin
                            m.m_awaddr  <= req_addr;
                            m.m_wdata   <= req_wdata;
                            m.m_wstrb   <= req_wstrb;
                            m.m_awvalid <= 1'b1;
                            m.m_wvalid  <= 1'b1;
                            state       <= AWW;
                        end else begin
                            m.m_araddr  <= req_addr;
                            m.m_arvalid <= 1'b1;
                            state       <= AR;
                        end
                    end
                end
                AR: begin
                    if (m.m_arready) begin
                        m.m_arvalid <= 1'b0;
                        m.m_rready  <= 1'b1;
                        state       <= R;
                    end
                end
                R: begin
                    if (m.m_rvalid) begin
                        rsp_rdata  <= m.m_rdata;
                        rsp_err    <= m.m_rresp[1];
                        m.m_rready <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end
                end
                AWW: begin
                    if (m.m_awvalid && m.m_awready) m.m_awvalid <= 1'b0;
                    if (m.m_wvalid && m.m_wready)   m.m_wvalid  <= 1'b0;
                    if (aw_done && w_done) begin
                        m.m_bready <= 1'b1;
                        state      <= B;
                    end
                end
                B: begin
                    if (m.m_bvalid) begin
                        rsp_rdata  <= '0;
                        rsp_err    <= m.m_bresp[1];
                        m.m_bready <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master_port.sv
// Directed bench for axi_lite_master_port: the bench plays the core and a
// hand-scripted AXI4-Lite slave, cycle by cycle.
module tb_axi_lite_master_port;
    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    int          pass_cnt = 0;
    int          chk_cnt  = 0;

    axi_lite_master_port_if m ();

    axi_lite_master_port #(.PROT(3'b000)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m(m.master)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_slave();
        m.m_arready = 1'b0; m.m_rvalid = 1'b0; m.m_rdata = '0; m.m_rresp = '0;
        m.m_awready = 1'b0; m.m_wready = 1'b0; m.m_bvalid = 1'b0; m.m_bresp = '0;
    endtask

    // Waits for req_ready, presents one request for a single cycle (cycle 0),
    // and returns at cycle 1.
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin step(); n++; end
        chk_cnt++;
        if (req_ready !== 1'b1) $display("FAIL req_ready_timeout got %b want 1", req_ready);
        else pass_cnt++;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        step();
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle_slave();
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        step(); step();
        chk_cnt++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata, m.m_arvalid, m.m_rready, m.m_awvalid,
             m.m_wvalid, m.m_bready, m.m_araddr, m.m_awaddr, m.m_wdata, m.m_wstrb} !== '0)
            $display("FAIL reset_outputs got nonzero want all 0 (req_ready=%b arvalid=%b rsp_rdata=%h)",
                     req_ready, m.m_arvalid, rsp_rdata);
        else pass_cnt++;
        rstn = 1'b1;
        step();
    endtask

    task automatic test_read();
        issue(1'b0, 32'h0000_1000, 32'h0, 4'h0);
        // cycle 1
        chk_cnt++;
        if ({m.m_arvalid, m.m_rready, req_ready, rsp_valid} !== 4'b1000)
            $display("FAIL rd_c1_ctrl got %b want 1000", {m.m_arvalid, m.m_rready, req_ready, rsp_valid});
        else pass_cnt++;
        chk_cnt++;
        if (m.m_araddr !== 32'h0000_1000 || m.m_arprot !== 3'b000)
            $display("FAIL rd_araddr got %h/%b want 00001000/000", m.m_araddr, m.m_arprot);
        else pass_cnt++;
        m.m_arready = 1'b1;
        step();
        // cycle 2
        m.m_arready = 1'b0;
        chk_cnt++;
        if ({m.m_arvalid, m.m_rready, rsp_valid} !== 3'b010)
            $display("FAIL rd_c2_ctrl got %b want 010", {m.m_arvalid, m.m_rready, rsp_valid});
        else pass_cnt++;
        m.m_rvalid = 1'b1; m.m_rdata = 32'hDEAD_BEEF; m.m_rresp = 2'b00;
        step();
        // cycle 3
        idle_slave();
        chk_cnt++;
        if ({rsp_valid, rsp_err, m.m_rready} !== 3'b100 || rsp_rdata !== 32'hDEAD_BEEF)
            $display("FAIL rd_rsp got v/e/rr=%b data=%h want 100 deadbeef",
                     {rsp_valid, rsp_err, m.m_rready}, rsp_rdata);
        else pass_cnt++;
        step();
        // cycle 4: pulse over, data held
        chk_cnt++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEAD_BEEF)
            $display("FAIL rd_pulse_end got v=%b data=%h want 0 deadbeef", rsp_valid, rsp_rdata);
        else pass_cnt++;
    endtask

    task automatic test_write_skew();
        issue(1'b1, 32'h0000_0010, 32'h1234_5678, 4'b0011);
        // cycle 1
        chk_cnt++;
        if ({m.m_awvalid, m.m_wvalid, m.m_bready} !== 3'b110 || m.m_awaddr !== 32'h10 ||
            m.m_wdata !== 32'h1234_5678 || m.m_wstrb !== 4'b0011 || m.m_awprot !== 3'b000)
            $display("FAIL wr_c1 got ctrl=%b addr=%h data=%h strb=%b want 110 10 12345678 0011",
                     {m.m_awvalid, m.m_wvalid, m.m_bready}, m.m_awaddr, m.m_wdata, m.m_wstrb);
        else pass_cnt++;
        m.m_wready = 1'b1;
        step();
        m.m_wready = 1'b0;
        // cycles 2..4: only awvalid high, no bready yet
        for (int c = 2; c <= 4; c++) begin
            chk_cnt++;
            if ({m.m_awvalid, m.m_wvalid, m.m_bready} !== 3'b100 || m.m_awaddr !== 32'h10)
                $display("FAIL wr_c%0d got ctrl=%b addr=%h want 100 10", c,
                         {m.m_awvalid, m.m_wvalid, m.m_bready}, m.m_awaddr);
            else pass_cnt++;
            if (c == 4) m.m_awready = 1'b1;
            step();
        end
        // cycle 5
        m.m_awready = 1'b0;
        chk_cnt++;
        if ({m.m_awvalid, m.m_wvalid, m.m_bready, rsp_valid} !== 4'b0010)
            $display("FAIL wr_c5 got %b want 0010", {m.m_awvalid, m.m_wvalid, m.m_bready, rsp_valid});
        else pass_cnt++;
        m.m_bvalid = 1'b1; m.m_bresp = 2'b00;
        step();
        // cycle 6
        idle_slave();
        chk_cnt++;
        if ({rsp_valid, rsp_err, m.m_bready} !== 3'b100 || rsp_rdata !== 32'h0)
            $display("FAIL wr_rsp got v/e/br=%b data=%h want 100 0",
                     {rsp_valid, rsp_err, m.m_bready}, rsp_rdata);
        else pass_cnt++;
        step();
    endtask

    task automatic test_ar_stall();
        issue(1'b0, 32'h0000_2468, 32'h0, 4'h0);
        // cycles 1..5: slave refuses the address
        for (int c = 1; c <= 5; c++) begin
            chk_cnt++;
            if ({m.m_arvalid, m.m_rready, req_ready, rsp_valid} !== 4'b1000 || m.m_araddr !== 32'h2468)
                $display("FAIL stall_c%0d got ctrl=%b addr=%h want 1000 2468", c,
                         {m.m_arvalid, m.m_rready, req_ready, rsp_valid}, m.m_araddr);
            else pass_cnt++;
            step();
        end
        m.m_arready = 1'b1;
        step();
        m.m_arready = 1'b0;
        m.m_rvalid = 1'b1; m.m_rdata = 32'h0000_A5A5; m.m_rresp = 2'b11;
        step();
        idle_slave();
        chk_cnt++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_A5A5 || rsp_err !== 1'b1)
            $display("FAIL stall_rsp got v=%b data=%h err=%b want 1 0000a5a5 1",
                     rsp_valid, rsp_rdata, rsp_err);
        else pass_cnt++;
        step();
    endtask

    task automatic test_err_then_ok();
        issue(1'b1, 32'h0000_0040, 32'hFFFF_0000, 4'b1111);
        m.m_awready = 1'b1; m.m_wready = 1'b1;
        step();
        idle_slave();
        chk_cnt++;
        if ({m.m_awvalid, m.m_wvalid, m.m_bready} !== 3'b001)
            $display("FAIL err_wr_c2 got %b want 001", {m.m_awvalid, m.m_wvalid, m.m_bready});
        else pass_cnt++;
        m.m_bvalid = 1'b1; m.m_bresp = 2'b10;
        step();
        idle_slave();
        chk_cnt++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0)
            $display("FAIL err_wr_rsp got v=%b err=%b data=%h want 1 1 0", rsp_valid, rsp_err, rsp_rdata);
        else pass_cnt++;
        step();
        issue(1'b0, 32'h0000_0044, 32'h0, 4'h0);
        m.m_arready = 1'b1;
        step();
        m.m_arready = 1'b0;
        m.m_rvalid = 1'b1; m.m_rdata = 32'h0000_0055; m.m_rresp = 2'b00;
        step();
        idle_slave();
        chk_cnt++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h55)
            $display("FAIL ok_rd_rsp got v=%b err=%b data=%h want 1 0 55", rsp_valid, rsp_err, rsp_rdata);
        else pass_cnt++;
        step();
    endtask

    task automatic test_reset_in_r();
        int seen = 0;
        issue(1'b0, 32'h0000_3000, 32'h0, 4'h0);
        m.m_arready = 1'b1;
        step();
        m.m_arready = 1'b0;
        // cycle 2: in R; reset asynchronously mid-cycle
        rstn = 1'b0;
        #1;
        chk_cnt++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata, m.m_arvalid, m.m_rready, m.m_awvalid,
             m.m_wvalid, m.m_bready, m.m_araddr} !== '0)
            $display("FAIL rst_in_r got rready=%b araddr=%h rsp_v=%b want all 0",
                     m.m_rready, m.m_araddr, rsp_valid);
        else pass_cnt++;
        m.m_rvalid = 1'b1; m.m_rdata = 32'h1111_1111;
        for (int c = 0; c < 3; c++) begin
            step();
            if (rsp_valid !== 1'b0) seen++;
        end
        idle_slave();
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            if (rsp_valid !== 1'b0) seen++;
        end
        chk_cnt++;
        if (seen != 0) $display("FAIL rst_no_rsp got %0d pulses want 0", seen);
        else pass_cnt++;
        issue(1'b0, 32'h0000_3004, 32'h0, 4'h0);
        chk_cnt++;
        if (m.m_arvalid !== 1'b1 || m.m_araddr !== 32'h3004)
            $display("FAIL post_rst_ar got v=%b addr=%h want 1 3004", m.m_arvalid, m.m_araddr);
        else pass_cnt++;
        m.m_arready = 1'b1;
        step();
        m.m_arready = 1'b0;
        m.m_rvalid = 1'b1; m.m_rdata = 32'hCAFE_F00D; m.m_rresp = 2'b00;
        step();
        idle_slave();
        chk_cnt++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D || rsp_err !== 1'b0)
            $display("FAIL post_rst_rsp got v=%b data=%h err=%b want 1 cafef00d 0",
                     rsp_valid, rsp_rdata, rsp_err);
        else pass_cnt++;
        step();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_skew();
        test_ar_stall();
        test_err_then_ok();
        test_reset_in_r();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
